// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the TPU tile sequencer and its helpers.
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_ADDRESSSIZE  = 10;
  localparam int DEF_WLOAD_CYCLES = 8;
  localparam int DEF_PIPE_LATENCY = 24;
  localparam int DEF_WTIMEOUT     = 255;

endpackage

// File: rtl/tpu_valid_delay.sv
// Shift register of valid bits that tracks activation rows through the array pipeline.
module tpu_valid_delay #(
  parameter int DEPTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // Shift-and-OR form keeps DEPTH=1 legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(din);
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Job controller: pops a weight tile, loads it, streams N activation rows and
// writes N aligned result rows, then pulses done.
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE  = DEF_ADDRESSSIZE,
  parameter int WLOAD_CYCLES = DEF_WLOAD_CYCLES,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int WTIMEOUT     = DEF_WTIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] dst_base,
  input  logic [ADDRESSSIZE-1:0] n_rows,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err_no_weights
);

  localparam int A  = ADDRESSSIZE;
  localparam int TW = $clog2(WTIMEOUT + 1);
  localparam int LW = $clog2(WLOAD_CYCLES + 1);

  state_t        state;
  logic [A-1:0]  src_r, dst_r, n_r;
  logic [A-1:0]  issue_cnt, wr_cnt;
  logic [TW-1:0] tcnt;
  logic [LW-1:0] lcnt;
  logic          dly_out;

  tpu_valid_delay #(.DEPTH(PIPE_LATENCY)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (ub_rd_en),
    .dout (dly_out)
  );

  assign res_we   = dly_out;
  assign res_addr = dst_r + wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      src_r            <= '0;
      dst_r            <= '0;
      n_r              <= '0;
      issue_cnt        <= '0;
      wr_cnt           <= '0;
      tcnt             <= '0;
      lcnt             <= '0;
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      ub_rd_en         <= 1'b0;
      ub_addr          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_no_weights   <= 1'b0;
    end else begin
      fifo_read_enable <= 1'b0;
      we_rl            <= 1'b0;
      ub_rd_en         <= 1'b0;
      ub_addr          <= '0;
      done             <= 1'b0;
      if (res_we) wr_cnt <= wr_cnt + A'(1);

      unique case (state)
        S_IDLE: begin
          if (start) begin
            src_r          <= src_base;
            dst_r          <= dst_base;
            n_r            <= n_rows;
            issue_cnt      <= '0;
            wr_cnt         <= '0;
            tcnt           <= '0;
            lcnt           <= '0;
            err_no_weights <= 1'b0;
            busy           <= 1'b1;
            state          <= (n_rows == '0) ? S_DONE : S_WAIT_W;
          end
        end
        S_WAIT_W: begin
          if (!fifo_empty) begin
            fifo_read_enable <= 1'b1;
            state            <= S_LOAD_W;
          end else if (tcnt == TW'(WTIMEOUT - 1)) begin
            err_no_weights <= 1'b1;
            done           <= 1'b1;
            state          <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_LOAD_W: begin
          we_rl <= 1'b1;
          lcnt  <= lcnt + LW'(1);
          if (lcnt == LW'(WLOAD_CYCLES - 1)) state <= S_STREAM;
        end
        S_STREAM: begin
          ub_rd_en  <= 1'b1;
          ub_addr   <= src_r + issue_cnt;
          issue_cnt <= issue_cnt + A'(1);
          if (issue_cnt == n_r - A'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // The write landing this cycle is the last one when it brings the count to N.
          if (res_we && (wr_cnt == n_r - A'(1))) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Entered with done already set on normal/timeout exits; an empty job
          // arrives with done low and raises it here, one cycle after start.
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench: each job pushes its expected pops, loads, reads, writes and
// done pulses with absolute cycle stamps; a negedge monitor pops and compares.
module tb_tpu_tile_sequencer;

  localparam int A = 10;
  localparam int W = 8;
  localparam int L = 24;
  localparam int WT = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [A-1:0] src_base = '0;
  logic [A-1:0] dst_base = '0;
  logic [A-1:0] n_rows = '0;
  logic         fifo_empty = 1'b0;
  logic         fifo_read_enable, we_rl, ub_rd_en, res_we, busy, done, err_no_weights;
  logic [A-1:0] ub_addr, res_addr;

  tpu_tile_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .src_base         (src_base),
    .dst_base         (dst_base),
    .n_rows           (n_rows),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .we_rl            (we_rl),
    .ub_rd_en         (ub_rd_en),
    .ub_addr          (ub_addr),
    .res_we           (res_we),
    .res_addr         (res_addr),
    .busy             (busy),
    .done             (done),
    .err_no_weights   (err_no_weights)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_wr[$];
  int  q_pop[$];
  int  q_wl[$];
  int  q_done[$];

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  int T;
  ev_t mon_ev;
  int  mon_c;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ub_rd_en && res_we) overlap++;
    if (fifo_read_enable) begin
      check("pop_expected", int'(q_pop.size() != 0), 1);
      if (q_pop.size() != 0) begin
        mon_c = q_pop.pop_front();
        check("pop_cycle", cyc, mon_c);
      end
    end
    if (we_rl) begin
      check("we_rl_expected", int'(q_wl.size() != 0), 1);
      if (q_wl.size() != 0) begin
        mon_c = q_wl.pop_front();
        check("we_rl_cycle", cyc, mon_c);
      end
    end
    if (ub_rd_en) begin
      check("rd_expected", int'(q_rd.size() != 0), 1);
      if (q_rd.size() != 0) begin
        mon_ev = q_rd.pop_front();
        check("rd_cycle", cyc, mon_ev.cyc);
        check("ub_addr", int'(ub_addr), mon_ev.addr);
      end
    end
    if (res_we) begin
      check("wr_expected", int'(q_wr.size() != 0), 1);
      if (q_wr.size() != 0) begin
        mon_ev = q_wr.pop_front();
        check("wr_cycle", cyc, mon_ev.cyc);
        check("res_addr", int'(res_addr), mon_ev.addr);
      end
    end
    if (done) begin
      check("done_expected", int'(q_done.size() != 0), 1);
      if (q_done.size() != 0) begin
        mon_c = q_done.pop_front();
        check("done_cycle", cyc, mon_c);
      end
    end
  end

  // Drive one start pulse; returns at the negedge right after the sampling edge T.
  task automatic start_job(input int src, input int dst, input int n, input bit weights);
    int s;
    @(negedge clk);
    src_base = A'(src);
    dst_base = A'(dst);
    n_rows   = A'(n);
    start    = 1'b1;
    T = cyc + 1;
    if (n == 0) begin
      q_done.push_back(T + 1);
    end else if (!weights) begin
      q_done.push_back(T + WT);
    end else begin
      q_pop.push_back(T + 1);
      for (int k = 0; k < W; k++) q_wl.push_back(T + 2 + k);
      s = T + 2 + W;
      for (int i = 0; i < n; i++) begin
        q_rd.push_back('{cyc: s + i, addr: (src + i) % 1024});
        q_wr.push_back('{cyc: s + L + i, addr: (dst + i) % 1024});
      end
      q_done.push_back(s + n + L);
    end
    @(negedge clk);
    start    = 1'b0;
    src_base = A'($urandom);
    dst_base = A'($urandom);
    n_rows   = A'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((busy || q_done.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("job_idle", int'(busy), 0);
    check("done_q_empty", q_done.size(), 0);
    check("rd_q_empty", q_rd.size(), 0);
    check("wr_q_empty", q_wr.size(), 0);
    check("pop_q_empty", q_pop.size(), 0);
    check("wl_q_empty", q_wl.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_res_we", int'(res_we), 0);
    check("rst_ub_rd_en", int'(ub_rd_en), 0);
    check("rst_err", int'(err_no_weights), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic job, plus an ignored start while busy
    start_job(12'h010, 12'h200, 4, 1'b1);
    check("t1_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    n_rows = 10'd7;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_idle(200);

    // Address wrap-around
    start_job(12'h3FE, 12'h3FF, 3, 1'b1);
    wait_idle(200);

    // Long job overlapping reads and writes
    overlap = 0;
    start_job(12'h100, 12'h050, 40, 1'b1);
    wait_idle(300);
    check("t3_overlap", overlap, 16);

    // Empty job
    start_job(12'h123, 12'h321, 0, 1'b0);
    wait_idle(20);

    // Weight timeout, then error cleared by next accepted start
    fifo_empty = 1'b1;
    start_job(12'h000, 12'h000, 5, 1'b0);
    wait_idle(400);
    check("t5_err_set", int'(err_no_weights), 1);
    repeat (2) @(negedge clk);
    check("t5_err_sticky", int'(err_no_weights), 1);
    fifo_empty = 1'b0;
    start_job(12'h020, 12'h040, 2, 1'b1);
    check("t5_err_cleared", int'(err_no_weights), 0);
    wait_idle(200);

    // Reset in the middle of streaming (after issue i=2 of 8)
    start_job(12'h080, 12'h180, 8, 1'b1);
    while (cyc < T + 2 + W + 2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ub_rd_en", int'(ub_rd_en), 0);
    check("t6_res_we", int'(res_we), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_we_rl", int'(we_rl), 0);
    check("t6_ub_addr", int'(ub_addr), 0);
    check("t6_res_addr", int'(res_addr), 0);
    q_rd.delete();
    q_wr.delete();
    q_pop.delete();
    q_wl.delete();
    q_done.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    start_job(12'h300, 12'h010, 3, 1'b1);
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #60000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
